// File: rtl/parallel_load_6bit_down_counter.sv
// ---------------------------------------------------------------------------
// parallel_load_6bit_down_counter
//
// Purpose:
//   6-bit down counter with synchronous clear, synchronous parallel load and
//   a count-down enable. On underflow it either wraps to MAX (WRAP = 1,
//   usable as a modulo-(MAX+1) digit of a cascaded timer) or stops at zero
//   and raises a sticky done flag (WRAP = 0, one-shot timer).
//
// Parameters:
//   MAX   - highest count value and the wrap target (legal range 1..63)
//   WRAP  - 1 = wrap to MAX on underflow, 0 = stop at zero and set done
//
// Ports:
//   clk     in   1  rising-edge clock
//   reset   in   1  asynchronous active-high reset
//   clear   in   1  synchronous clear to zero (highest priority)
//   load    in   1  synchronous parallel load of in (saturated to MAX)
//   en      in   1  decrement request
//   in      in   6  parallel load value
//   out     out  6  registered count value
//   borrow  out  1  combinational borrow into the next-higher stage
//   zero    out  1  combinational flag, out == 0
//   done    out  1  registered sticky expiry flag (WRAP = 0 only)
// ---------------------------------------------------------------------------
module parallel_load_6bit_down_counter #(
  parameter int unsigned MAX  = 59,
  parameter bit          WRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic       en,
  input  logic [5:0] in,
  output logic [5:0] out,
  output logic       borrow,
  output logic       zero,
  output logic       done
);

  // An out-of-range MAX is pulled back into 1..63 so the comparator and the
  // wrap value always fit the 6-bit datapath.
  localparam int unsigned MAX_CLAMPED = (MAX < 1) ? 1 : ((MAX > 63) ? 63 : MAX);
  localparam logic [5:0]  C_MAX       = 6'(MAX_CLAMPED);

  // COUNT holds every nonzero value, AT_ZERO is a zero that may still wrap
  // or expire, EXPIRED is only reachable in one-shot mode.
  typedef enum logic [1:0] {
    ST_COUNT   = 2'd0,
    ST_AT_ZERO = 2'd1,
    ST_EXPIRED = 2'd2
  } counterState_t;

  counterState_t r_state;
  logic [5:0]    r_out;
  logic          r_done;

  logic [5:0]    w_loadValue;
  logic          w_loadIsZero;
  logic          w_outIsZero;

  // Load values above MAX saturate so out can never leave 0..MAX.
  assign w_loadValue  = (in > C_MAX) ? C_MAX : in;
  assign w_loadIsZero = (w_loadValue == 6'd0);
  assign w_outIsZero  = (r_out == 6'd0);

  // Counter state machine. clear beats load beats en; state, count and done
  // all update together so done and the state encoding can never disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out   <= 6'd0;
      r_done  <= 1'b0;
      r_state <= ST_AT_ZERO;
    end else if (clear) begin
      r_out   <= 6'd0;
      r_done  <= 1'b0;
      r_state <= ST_AT_ZERO;
    end else if (load) begin
      r_out   <= w_loadValue;
      r_done  <= 1'b0;
      r_state <= w_loadIsZero ? ST_AT_ZERO : ST_COUNT;
    end else if (en) begin
      case (r_state)
        ST_COUNT: begin
          r_out <= r_out - 6'd1;
          if (r_out == 6'd1) begin
            r_state <= ST_AT_ZERO;
          end
        end
        ST_AT_ZERO: begin
          if (WRAP) begin
            r_out   <= C_MAX;
            r_state <= ST_COUNT;
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_EXPIRED;
          end
        end
        ST_EXPIRED: begin
          // Sticky: only clear, load or reset leave this state.
          r_out <= r_out;
        end
        default: begin
          r_out   <= 6'd0;
          r_done  <= 1'b0;
          r_state <= ST_AT_ZERO;
        end
      endcase
    end
  end

  // borrow fires in the cycle that the underflow edge is about to happen, so
  // a higher stage driven by it steps on that same edge. reset is folded in
  // because the async-cleared zero would otherwise look like a live underflow.
  assign borrow = en & ~load & ~clear & w_outIsZero & ~r_done & ~reset;

  assign out  = r_out;
  assign zero = w_outIsZero;
  assign done = r_done;

endmodule

// File: tb/tb_parallel_load_6bit_down_counter.sv
// ---------------------------------------------------------------------------
// tb_parallel_load_6bit_down_counter
//
// Purpose:
//   Directed bench for parallel_load_6bit_down_counter. Instance A is a
//   wrapping MAX=59 counter, instance B a one-shot (WRAP=0) counter, and
//   C is a two-stage cascade (lo digit borrow drives hi digit en).
//   Each row drives inputs just after a rising edge and queues the expected
//   outputs for that cycle; a monitor pops the queue on the falling edge.
// ---------------------------------------------------------------------------
module tb_parallel_load_6bit_down_counter;

  logic clk = 1'b0;
  logic reset;

  logic       clearA, loadA, enA;
  logic [5:0] inA;
  logic [5:0] outA;
  logic       borrowA, zeroA, doneA;

  logic       clearB, loadB, enB;
  logic [5:0] inB;
  logic [5:0] outB;
  logic       borrowB, zeroB, doneB;

  logic       clearC, loadC, enC;
  logic [5:0] inLoC, inHiC;
  logic [5:0] outLoC, outHiC;
  logic       borrowLoC, zeroLoC, doneLoC;
  logic       borrowHiC, zeroHiC, doneHiC;

  typedef struct {
    string      name;
    int         id;
    logic [5:0] out;
    logic [5:0] outHi;
    logic       zero;
    logic       borrow;
    logic       done;
  } expEntry_t;

  expEntry_t sbQ[$];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  parallel_load_6bit_down_counter #(.MAX(59), .WRAP(1'b1)) dutA (
    .clk(clk), .reset(reset), .clear(clearA), .load(loadA), .en(enA), .in(inA),
    .out(outA), .borrow(borrowA), .zero(zeroA), .done(doneA)
  );

  parallel_load_6bit_down_counter #(.MAX(59), .WRAP(1'b0)) dutB (
    .clk(clk), .reset(reset), .clear(clearB), .load(loadB), .en(enB), .in(inB),
    .out(outB), .borrow(borrowB), .zero(zeroB), .done(doneB)
  );

  parallel_load_6bit_down_counter #(.MAX(59), .WRAP(1'b1)) dutLo (
    .clk(clk), .reset(reset), .clear(clearC), .load(loadC), .en(enC), .in(inLoC),
    .out(outLoC), .borrow(borrowLoC), .zero(zeroLoC), .done(doneLoC)
  );

  parallel_load_6bit_down_counter #(.MAX(59), .WRAP(1'b1)) dutHi (
    .clk(clk), .reset(reset), .clear(clearC), .load(loadC), .en(borrowLoC), .in(inHiC),
    .out(outHiC), .borrow(borrowHiC), .zero(zeroHiC), .done(doneHiC)
  );

  // Drive one row of stimulus just after the rising edge; groups not
  // selected by id are left idle so they hold their count.
  task automatic applyStimulus(input int id, input logic rst, input logic c,
                               input logic l, input logic e,
                               input logic [5:0] v, input logic [5:0] vHi);
    @(posedge clk);
    #1;
    reset  = rst;
    clearA = 1'b0; loadA = 1'b0; enA = 1'b0; inA = 6'd0;
    clearB = 1'b0; loadB = 1'b0; enB = 1'b0; inB = 6'd0;
    clearC = 1'b0; loadC = 1'b0; enC = 1'b0; inLoC = 6'd0; inHiC = 6'd0;
    case (id)
      0: begin clearA = c; loadA = l; enA = e; inA = v; end
      1: begin clearB = c; loadB = l; enB = e; inB = v; end
      default: begin clearC = c; loadC = l; enC = e; inLoC = v; inHiC = vHi; end
    endcase
  endtask

  // Queue the outputs expected at the next falling edge.
  task automatic checkOutput(input string nm, input int id, input logic [5:0] o,
                             input logic [5:0] oHi, input logic z, input logic b,
                             input logic d);
    expEntry_t e;
    e.name = nm; e.id = id; e.out = o; e.outHi = oHi;
    e.zero = z; e.borrow = b; e.done = d;
    sbQ.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the selected instance.
  always @(negedge clk) begin
    while (sbQ.size() > 0) begin
      expEntry_t e;
      logic [5:0] aOut, aHi;
      logic aZero, aBorrow, aDone;
      e = sbQ.pop_front();
      case (e.id)
        0: begin aOut = outA; aHi = 6'd0; aZero = zeroA; aBorrow = borrowA; aDone = doneA; end
        1: begin aOut = outB; aHi = 6'd0; aZero = zeroB; aBorrow = borrowB; aDone = doneB; end
        default: begin aOut = outLoC; aHi = outHiC; aZero = zeroLoC; aBorrow = borrowLoC; aDone = doneLoC; end
      endcase
      checks++;
      if ({aOut, aHi, aZero, aBorrow, aDone} === {e.out, e.outHi, e.zero, e.borrow, e.done}) begin
        passes++;
      end else begin
        $display("[TB] FAIL %s: got out=%0d hi=%0d zero=%b borrow=%b done=%b, expected out=%0d hi=%0d zero=%b borrow=%b done=%b",
                 e.name, aOut, aHi, aZero, aBorrow, aDone, e.out, e.outHi, e.zero, e.borrow, e.done);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    clearA = 1'b0; loadA = 1'b0; enA = 1'b1; inA = 6'd0;
    clearB = 1'b0; loadB = 1'b0; enB = 1'b0; inB = 6'd0;
    clearC = 1'b0; loadC = 1'b0; enC = 1'b0; inLoC = 6'd0; inHiC = 6'd0;

    // Reset behaviour and first wrap after release (instance A)
    applyStimulus(0, 1, 0, 0, 1, 6'd0, 6'd0);  checkOutput("resetHold",    0, 6'd0,  6'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 6'd0, 6'd0);  checkOutput("relBorrow",    0, 6'd0,  6'd0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 6'd0, 6'd0);  checkOutput("wrapAfterRst", 0, 6'd59, 6'd0, 0, 0, 0);

    // Load 5 then count down through zero to MAX
    applyStimulus(0, 0, 0, 1, 0, 6'd5, 6'd0);  checkOutput("loadIssue",    0, 6'd59, 6'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 6'd0, 6'd0);  checkOutput("cnt5",         0, 6'd5,  6'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 6'd0, 6'd0);  checkOutput("cnt4",         0, 6'd4,  6'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 6'd0, 6'd0);  checkOutput("cnt3",         0, 6'd3,  6'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 6'd0, 6'd0);  checkOutput("cnt2",         0, 6'd2,  6'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 6'd0, 6'd0);  checkOutput("cnt1",         0, 6'd1,  6'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 6'd0, 6'd0);  checkOutput("cnt0Borrow",   0, 6'd0,  6'd0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 6'd0, 6'd0);  checkOutput("wrap59",       0, 6'd59, 6'd0, 0, 0, 0);

    // Saturation of oversized load, and load of zero
    applyStimulus(0, 0, 0, 1, 0, 6'd7, 6'd0);  checkOutput("satPre",       0, 6'd59, 6'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 6'd62, 6'd0); checkOutput("load7",        0, 6'd7,  6'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 6'd0, 6'd0);  checkOutput("sat59",        0, 6'd59, 6'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 6'd0, 6'd0);  checkOutput("load0Issue",   0, 6'd59, 6'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 6'd0, 6'd0);  checkOutput("load0Zero",    0, 6'd0,  6'd0, 1, 0, 0);

    // Priority: clear > load > en
    applyStimulus(0, 0, 0, 1, 0, 6'd20, 6'd0); checkOutput("prioPre",      0, 6'd0,  6'd0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 1, 6'd10, 6'd0); checkOutput("prioIssue",    0, 6'd20, 6'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 6'd10, 6'd0); checkOutput("clearWins",    0, 6'd0,  6'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 6'd0, 6'd0);  checkOutput("loadOverEn",   0, 6'd10, 6'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 6'd0, 6'd0);  checkOutput("hold",         0, 6'd10, 6'd0, 0, 0, 0);

    // One-shot mode (instance B)
    applyStimulus(1, 0, 0, 1, 0, 6'd2, 6'd0);  checkOutput("osIdle",       1, 6'd0,  6'd0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 6'd0, 6'd0);  checkOutput("os2",          1, 6'd2,  6'd0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 6'd0, 6'd0);  checkOutput("os1",          1, 6'd1,  6'd0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 6'd0, 6'd0);  checkOutput("os0Borrow",    1, 6'd0,  6'd0, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 6'd0, 6'd0);  checkOutput("osExpired",    1, 6'd0,  6'd0, 1, 0, 1);
    #1;
    checks++;
    if (doneB === 1'b1 && outB === 6'd0) begin
      passes++;
    end else begin
      $display("[TB] FAIL osDirect: got out=%0d done=%b, expected out=0 done=1", outB, doneB);
    end
    applyStimulus(1, 0, 0, 0, 1, 6'd0, 6'd0);  checkOutput("osStays",      1, 6'd0,  6'd0, 1, 0, 1);
    applyStimulus(1, 0, 0, 1, 0, 6'd3, 6'd0);  checkOutput("osLoadIssue",  1, 6'd0,  6'd0, 1, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 6'd0, 6'd0);  checkOutput("osReload",     1, 6'd3,  6'd0, 0, 0, 0);

    // Two-stage cascade: 1:00 -> 0:59 -> 0:58
    applyStimulus(2, 0, 0, 1, 0, 6'd0, 6'd1);  checkOutput("cascLoad",     2, 6'd0,  6'd0, 1, 0, 0);
    applyStimulus(2, 0, 0, 0, 1, 6'd0, 6'd0);  checkOutput("cascBorrow",   2, 6'd0,  6'd1, 1, 1, 0);
    applyStimulus(2, 0, 0, 0, 1, 6'd0, 6'd0);  checkOutput("casc059",      2, 6'd59, 6'd0, 0, 0, 0);
    applyStimulus(2, 0, 0, 0, 0, 6'd0, 6'd0);  checkOutput("casc058",      2, 6'd58, 6'd0, 0, 0, 0);

    // Asynchronous reset mid-count (instance A)
    applyStimulus(0, 0, 0, 1, 0, 6'd37, 6'd0); checkOutput("load37Issue",  0, 6'd10, 6'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 6'd0, 6'd0);  checkOutput("at37",         0, 6'd37, 6'd0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 6'd0, 6'd0);  checkOutput("asyncRst",     0, 6'd0,  6'd0, 1, 0, 0);
    #1;
    checks++;
    if (outA === 6'd0) begin
      passes++;
    end else begin
      $display("[TB] FAIL asyncRstOut: got out=%0d, expected out=0 before next edge", outA);
    end
    checks++;
    if (zeroA === 1'b1 && borrowA === 1'b0 && doneA === 1'b0) begin
      passes++;
    end else begin
      $display("[TB] FAIL asyncRstFlags: got zero=%b borrow=%b done=%b, expected 1 0 0", zeroA, borrowA, doneA);
    end
    applyStimulus(0, 0, 0, 0, 0, 6'd0, 6'd0);  checkOutput("rstRelHold",   0, 6'd0,  6'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 6'd0, 6'd0);  checkOutput("stillZero",    0, 6'd0,  6'd0, 1, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    while (sbQ.size() > 0) begin
      expEntry_t e;
      e = sbQ.pop_front();
      checks++;
      $display("[TB] FAIL %s: expectation never compared, got none, expected out=%0d", e.name, e.out);
    end

    if (passes == checks) begin
      $display("[TB] PASS all checks");
    end else begin
      $display("[TB] FAIL %0d checks failed", checks - passes);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
